// File: rtl/baud_generator.sv
// baud_generator: free-running divider producing the UART bit/sample clock.
// The output is low for the ceiling half of the divisor and high for the
// floor half, and comes straight from a flop so it is glitch-free.
module baud_generator #(
  parameter int BAUD_RATE  = 9600,
  parameter int CLK_FREQ   = 83_333_333,
  parameter int OVERSAMPLE = 1
) (
  input  logic clk,
  input  logic rst,
  output logic UART_clk
);

  // Target output rate and the divisor rounded to the nearest integer.
  localparam int RATE = BAUD_RATE * OVERSAMPLE;
  localparam int DIV  = (CLK_FREQ + RATE / 2) / RATE;
  localparam int LOW  = DIV - DIV / 2;
  localparam int CW   = (DIV < 2) ? 1 : $clog2(DIV);

  // A divisor below 2 cannot produce a square wave from a single counter.
  generate
    if (DIV < 2) begin : g_div_check
      $fatal(1, "baud_generator: divisor %0d is below 2", DIV);
    end
  endgenerate

  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_next;

  // Next count: 0..DIV-1 then wrap.
  always_comb begin
    cnt_next = cnt + CW'(1);
    if (cnt == CW'(DIV - 1)) begin
      cnt_next = '0;
    end
  end

  // Counter and registered output; output is derived from the next count so
  // that UART_clk always equals (cnt >= LOW) without an extra cycle of lag.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      UART_clk <= 1'b0;
    end else begin
      cnt      <= cnt_next;
      UART_clk <= (cnt_next >= CW'(LOW));
    end
  end

endmodule

// File: tb/tb_baud_generator.sv
// tb_baud_generator: scoreboard bench for baud_generator covering the default
// divisor, 16x oversampling, DIV=5, DIV=2 and mid-period reset.
module tb_baud_generator;

  logic clk = 1'b0;
  always #12 clk = ~clk;

  logic rst0 = 1'b1;
  logic rst5 = 1'b1;
  logic rst2 = 1'b1;
  logic u0, u16, u5, u2;

  baud_generator d0 (.clk(clk), .rst(rst0), .UART_clk(u0));

  baud_generator #(.BAUD_RATE(9600), .CLK_FREQ(83_333_333), .OVERSAMPLE(16))
    d16 (.clk(clk), .rst(rst0), .UART_clk(u16));

  baud_generator #(.BAUD_RATE(1), .CLK_FREQ(5), .OVERSAMPLE(1))
    d5 (.clk(clk), .rst(rst5), .UART_clk(u5));

  baud_generator #(.BAUD_RATE(2), .CLK_FREQ(4), .OVERSAMPLE(1))
    d2 (.clk(clk), .rst(rst2), .UART_clk(u2));

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk_val(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (%b), expected %0d", name, act, act, exp);
    end
  endtask

  typedef struct {
    logic u;
    int   c;
    bit   use_c;
  } exp_t;

  // Per-edge expectations (one entry per rising edge) and measurement
  // expectations (first rise edge, then period/high pairs).
  exp_t q0[$];
  exp_t q5[$];
  exp_t q2[$];
  int   qp0[$];
  int   qp16[$];
  bit   done5 = 1'b0;
  bit   done2 = 1'b0;

  // Per-edge monitors: one expectation consumed per clock, sampled at negedge.
  always @(negedge clk) begin
    if (q0.size() > 0) begin
      exp_t e;
      e = q0.pop_front();
      chk_val("d0_uart_clk", 32'(u0), 32'(e.u));
    end
  end

  always @(negedge clk) begin
    if (q5.size() > 0) begin
      exp_t e;
      e = q5.pop_front();
      chk_val("d5_uart_clk", 32'(u5), 32'(e.u));
      if (e.use_c) chk_val("d5_cnt", 32'(d5.cnt), e.c);
    end
  end

  always @(negedge clk) begin
    if (q2.size() > 0) begin
      exp_t e;
      e = q2.pop_front();
      chk_val("d2_uart_clk", 32'(u2), 32'(e.u));
      if (e.use_c) chk_val("d2_cnt", 32'(d2.cnt), e.c);
    end
  end

  // Edges since release of rst0 (shared by d0 and d16).
  int ec = 0;
  always @(posedge clk) ec <= rst0 ? 0 : ec + 1;

  // Period/high-time monitors: act on each observed rise of the output.
  logic p0 = 1'b0, p16 = 1'b0;
  bit   seen0 = 1'b0, seen16 = 1'b0;
  int   lr0 = 0, lf0 = 0, lr16 = 0, lf16 = 0;

  always @(negedge clk) begin
    if (u0 === 1'b1 && p0 === 1'b0) begin
      if (!seen0) begin
        if (qp0.size() > 0) chk_val("d0_first_rise_edge", ec, qp0.pop_front());
        seen0 <= 1'b1;
      end else if (qp0.size() >= 2) begin
        chk_val("d0_period", ec - lr0, qp0.pop_front());
        chk_val("d0_high", lf0 - lr0, qp0.pop_front());
      end
      lr0 <= ec;
    end
    if (u0 === 1'b0 && p0 === 1'b1) lf0 <= ec;
    p0 <= u0;
  end

  always @(negedge clk) begin
    if (u16 === 1'b1 && p16 === 1'b0) begin
      if (!seen16) begin
        if (qp16.size() > 0) chk_val("d16_first_rise_edge", ec, qp16.pop_front());
        seen16 <= 1'b1;
      end else if (qp16.size() >= 2) begin
        chk_val("d16_period", ec - lr16, qp16.pop_front());
        chk_val("d16_high", lf16 - lr16, qp16.pop_front());
      end
      lr16 <= ec;
    end
    if (u16 === 1'b0 && p16 === 1'b1) lf16 <= ec;
    p16 <= u16;
  end

  // DIV=5 stimulus: run 13 edges, reset while high, then restart.
  logic u5tab[13] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
  int   c5tab[13] = '{1, 2, 3, 4, 0, 1, 2, 3, 4, 0, 1, 2, 3};
  initial begin
    q5.push_back('{1'b0, 0, 1'b1});
    @(negedge clk);
    #1 rst5 = 1'b0;
    for (int i = 0; i < 13; i++) q5.push_back('{u5tab[i], c5tab[i], 1'b1});
    repeat (13) @(negedge clk);
    #1 rst5 = 1'b1;
    q5.push_back('{1'b0, 0, 1'b1});
    @(negedge clk);
    #1 rst5 = 1'b0;
    for (int i = 0; i < 5; i++) q5.push_back('{u5tab[i], c5tab[i], 1'b1});
    done5 = 1'b1;
  end

  // DIV=2 stimulus: output toggles every edge, high after edge 1.
  initial begin
    q2.push_back('{1'b0, 0, 1'b1});
    @(negedge clk);
    #1 rst2 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      q2.push_back('{((i % 2) == 0) ? 1'b1 : 1'b0, ((i % 2) == 0) ? 1 : 0, 1'b1});
    end
    done2 = 1'b1;
  end

  // Defaults and 16x: reset edge, 1000 ns of low output, then measurements.
  initial begin
    bit finished;
    finished = 1'b0;
    q0.push_back('{1'b0, 0, 1'b0});
    qp0.push_back(4341);
    for (int i = 0; i < 5; i++) begin
      qp0.push_back(8681);
      qp0.push_back(4340);
    end
    qp16.push_back(272);
    for (int i = 0; i < 10; i++) begin
      qp16.push_back(543);
      qp16.push_back(271);
    end
    #20 rst0 = 1'b0;
    for (int i = 0; i < 41; i++) q0.push_back('{1'b0, 0, 1'b0});

    for (int i = 0; i < 60000; i++) begin
      @(negedge clk);
      #2;
      if (done5 && done2 && q0.size() == 0 && q5.size() == 0 && q2.size() == 0 &&
          qp0.size() == 0 && qp16.size() == 0) begin
        finished = 1'b1;
        break;
      end
    end
    if (!finished) begin
      n_checks++;
      n_fail++;
      $display("FAIL timeout: pending q0=%0d q5=%0d q2=%0d qp0=%0d qp16=%0d, expected all 0",
               q0.size(), q5.size(), q2.size(), qp0.size(), qp16.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
